// File: rtl/xm23_dev_pkg.sv
// Shared definitions for the XM23 device responder: CSR bit layout, device
// indices and register offsets.
package xm23_dev_pkg;

   localparam int CSR_IE  = 0;
   localparam int CSR_IO  = 1;
   localparam int CSR_DBA = 2;
   localparam int CSR_OF  = 3;
   localparam int CSR_ENA = 4;

   localparam int DEV_RX  = 0;
   localparam int DEV_TX  = 1;
   localparam int DEV_TMR = 2;
   localparam int NUM_DEV = 3;

   // First offset past the decoded window, with and without the timer pair
   localparam logic [15:0] OFF_LIMIT_BASE = 16'd4;
   localparam logic [15:0] OFF_LIMIT_TMR  = 16'd6;

   typedef struct packed {
      logic ena;
      logic of;
      logic dba;
      logic io;
      logic ie;
   } dev_csr_t;

   function automatic logic [7:0] csr_pack(input dev_csr_t c);
      logic [7:0] b;
      b          = 8'h00;
      b[CSR_IE]  = c.ie;
      b[CSR_IO]  = c.io;
      b[CSR_DBA] = c.dba;
      b[CSR_OF]  = c.of;
      b[CSR_ENA] = c.ena;
      return b;
   endfunction

endpackage

// File: rtl/xm23_irq_arbiter.sv
// Pending-bit register with fixed priority (lowest device index wins) and
// acknowledge of the currently presented vector.
module xm23_irq_arbiter
   import xm23_dev_pkg::*;
#(
   parameter logic [3:0] VECT_BASE = 4'd0
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NUM_DEV-1:0] pend_set,
   input  logic               int_ack,
   output logic               int_req,
   output logic [3:0]         int_vect
);

   logic [NUM_DEV-1:0] pend_reg;
   logic [NUM_DEV-1:0] pend_next;
   logic [NUM_DEV-1:0] ack_sel;
   logic [1:0]         win;

   always_comb begin
      win = 2'd0;
      for (int i = NUM_DEV - 1; i >= 0; i--) begin
         if (pend_reg[i]) win = 2'(i);
      end
   end

   // A new event in the ack cycle keeps its bit set
   genvar gi;
   generate
      for (gi = 0; gi < NUM_DEV; gi++) begin : g_pend
         assign ack_sel[gi]   = int_ack && pend_reg[gi] && (win == 2'(gi));
         assign pend_next[gi] = (pend_reg[gi] & ~ack_sel[gi]) | pend_set[gi];
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) pend_reg <= '0;
      else        pend_reg <= pend_next;
   end

   assign int_req  = |pend_reg;
   assign int_vect = VECT_BASE + {2'b00, win};

endmodule

// File: rtl/xm23_dev_responder.sv
// XM23 device-space bus responder: stream receiver, stream transmitter and,
// when DEV_TIMER_EN is defined, an interval timer on the third CSR/DR pair.
module xm23_dev_responder
   import xm23_dev_pkg::*;
#(
   parameter logic [15:0] BASE_ADDR = 16'h0000,
   parameter logic [3:0]  VECT_BASE = 4'd0,
   parameter logic [15:0] TICK_DIV  = 16'd50000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] addr,
   input  logic [15:0] wdata,
   input  logic        rd_en,
   input  logic        wr_en,
   input  logic        byte_sel,
   output logic [15:0] rdata,
   output logic        ack,
   input  logic        rx_valid,
   input  logic [7:0]  rx_data,
   output logic        rx_ready,
   output logic        tx_valid,
   output logic [7:0]  tx_data,
   input  logic        tx_ready,
   output logic        int_req,
   output logic [3:0]  int_vect,
   input  logic        int_ack
);

   logic [15:0] off;
   logic [1:0]  dev;
   logic        odd, in_range, rd;
   logic        csr_wr_sel, dr_wr_sel, dr_rd_sel;
   logic [7:0]  csr_wbyte, dr_wbyte;

`ifdef DEV_TIMER_EN
   assign in_range = off < OFF_LIMIT_TMR;
`else
   assign in_range = off < OFF_LIMIT_BASE;
`endif

   // Even-offset word accesses touch both CSR and DR; everything else one byte
   assign off        = addr - BASE_ADDR;
   assign dev        = off[2:1];
   assign odd        = off[0];
   assign rd         = rd_en & ~wr_en;
   assign csr_wr_sel = wr_en & in_range & ~odd;
   assign dr_wr_sel  = wr_en & in_range & (odd | ~byte_sel);
   assign dr_rd_sel  = rd & in_range & (odd | ~byte_sel);
   assign csr_wbyte  = wdata[7:0];
   assign dr_wbyte   = odd ? wdata[7:0] : wdata[15:8];

   logic [NUM_DEV-1:0] pend_set;

   // Receiver
   logic       ie0_reg, ena0_reg, dba0_reg, of0_reg;
   logic [7:0] dr0_reg;
   logic       rx_fire, csr0_wr, dr0_rd;
   dev_csr_t   csr0;

   assign rx_fire = rx_valid & ena0_reg;
   assign csr0_wr = csr_wr_sel && (dev == 2'(DEV_RX));
   assign dr0_rd  = dr_rd_sel && (dev == 2'(DEV_RX));
   assign csr0    = '{ena: ena0_reg, of: of0_reg, dba: dba0_reg, io: 1'b0, ie: ie0_reg};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ie0_reg  <= 1'b0;
         ena0_reg <= 1'b1;
         dba0_reg <= 1'b0;
         of0_reg  <= 1'b0;
         dr0_reg  <= 8'h00;
      end else begin
         if (csr0_wr) begin
            ie0_reg  <= csr_wbyte[CSR_IE];
            ena0_reg <= csr_wbyte[CSR_ENA];
            if (!csr_wbyte[CSR_OF]) of0_reg <= 1'b0;
         end
         // A read consuming the old byte in the arrival cycle is not an overrun
         if (rx_fire) begin
            dr0_reg  <= rx_data;
            dba0_reg <= 1'b1;
            if (dba0_reg && !dr0_rd) of0_reg <= 1'b1;
         end else if (dr0_rd) begin
            dba0_reg <= 1'b0;
         end
      end
   end

   assign rx_ready          = ena0_reg;
   assign pend_set[DEV_RX]  = rx_fire & ie0_reg;

   // Transmitter; the data buffer is available exactly when nothing is in flight
   logic       ie1_reg, ena1_reg, of1_reg, tx_valid_reg;
   logic [7:0] tx_data_reg;
   logic       tx_done, csr1_wr, dr1_store;
   dev_csr_t   csr1;

   assign tx_done   = tx_valid_reg & tx_ready;
   assign csr1_wr   = csr_wr_sel && (dev == 2'(DEV_TX));
   assign dr1_store = dr_wr_sel && (dev == 2'(DEV_TX)) && ena1_reg;
   assign csr1      = '{ena: ena1_reg, of: of1_reg, dba: ~tx_valid_reg, io: 1'b1, ie: ie1_reg};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ie1_reg      <= 1'b0;
         ena1_reg     <= 1'b1;
         of1_reg      <= 1'b0;
         tx_valid_reg <= 1'b0;
         tx_data_reg  <= 8'h00;
      end else begin
         if (csr1_wr) begin
            ie1_reg  <= csr_wbyte[CSR_IE];
            ena1_reg <= csr_wbyte[CSR_ENA];
            if (!csr_wbyte[CSR_OF]) of1_reg <= 1'b0;
         end
         if (dr1_store) begin
            tx_data_reg  <= dr_wbyte;
            tx_valid_reg <= 1'b1;
            if (tx_valid_reg && !tx_done) of1_reg <= 1'b1;
         end else if (tx_done) begin
            tx_valid_reg <= 1'b0;
         end
      end
   end

   assign tx_valid         = tx_valid_reg;
   assign tx_data          = tx_data_reg;
   assign pend_set[DEV_TX] = tx_done & ie1_reg;

   logic [7:0] csr2_val, dr2_val;

`ifdef DEV_TIMER_EN
   logic        ie2_reg, ena2_reg, dba2_reg, of2_reg;
   logic [7:0]  dr2_reg, cnt_reg;
   logic [15:0] presc_reg;
   logic        csr2_wr, dr2_wr, csr2_rd, tick, tmr_evt;
   dev_csr_t    csr2;

   assign csr2_wr = csr_wr_sel && (dev == 2'(DEV_TMR));
   assign dr2_wr  = dr_wr_sel && (dev == 2'(DEV_TMR));
   assign csr2_rd = rd && in_range && !odd && (dev == 2'(DEV_TMR));
   assign tick    = ena2_reg && (cnt_reg != 8'h00) && (presc_reg == TICK_DIV - 16'd1);
   assign tmr_evt = tick && (cnt_reg == 8'h01);
   assign csr2    = '{ena: ena2_reg, of: of2_reg, dba: dba2_reg, io: 1'b0, ie: ie2_reg};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ie2_reg   <= 1'b0;
         ena2_reg  <= 1'b0;
         dba2_reg  <= 1'b0;
         of2_reg   <= 1'b0;
         dr2_reg   <= 8'h00;
         cnt_reg   <= 8'h00;
         presc_reg <= 16'h0000;
      end else begin
         if (csr2_wr) begin
            ie2_reg  <= csr_wbyte[CSR_IE];
            ena2_reg <= csr_wbyte[CSR_ENA];
            if (!csr_wbyte[CSR_OF]) of2_reg <= 1'b0;
         end
         if (dr2_wr) begin
            dr2_reg   <= dr_wbyte;
            cnt_reg   <= dr_wbyte;
            presc_reg <= 16'h0000;
         end else if (ena2_reg && (cnt_reg != 8'h00)) begin
            if (tick) begin
               presc_reg <= 16'h0000;
               cnt_reg   <= tmr_evt ? dr2_reg : cnt_reg - 8'd1;
            end else begin
               presc_reg <= presc_reg + 16'd1;
            end
         end
         if (tmr_evt) begin
            dba2_reg <= 1'b1;
            if (dba2_reg && !csr2_rd) of2_reg <= 1'b1;
         end else if (csr2_rd) begin
            dba2_reg <= 1'b0;
         end
      end
   end

   assign csr2_val          = csr_pack(csr2);
   assign dr2_val           = dr2_reg;
   assign pend_set[DEV_TMR] = tmr_evt & ie2_reg;
`else
   assign csr2_val          = 8'h00;
   assign dr2_val           = 8'h00;
   assign pend_set[DEV_TMR] = 1'b0;
`endif

   logic [7:0]  csr_val, dr_val;
   logic [15:0] rdata_next;
   logic [15:0] rdata_reg;
   logic        ack_reg;

   always_comb begin
      csr_val = 8'h00;
      dr_val  = 8'h00;
      case (dev)
         2'(DEV_RX):  begin csr_val = csr_pack(csr0); dr_val = dr0_reg;     end
         2'(DEV_TX):  begin csr_val = csr_pack(csr1); dr_val = tx_data_reg; end
         2'(DEV_TMR): begin csr_val = csr2_val;       dr_val = dr2_val;     end
         default: ;
      endcase
      rdata_next = 16'h0000;
      if (rd && in_range) begin
         if (odd)           rdata_next = {8'h00, dr_val};
         else if (byte_sel) rdata_next = {8'h00, csr_val};
         else               rdata_next = {dr_val, csr_val};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdata_reg <= 16'h0000;
         ack_reg   <= 1'b0;
      end else begin
         rdata_reg <= rdata_next;
         ack_reg   <= rd_en | wr_en;
      end
   end

   assign rdata = rdata_reg;
   assign ack   = ack_reg;

   xm23_irq_arbiter #(
      .VECT_BASE (VECT_BASE)
   ) u_irq (
      .clk      (clk),
      .rst_n    (rst_n),
      .pend_set (pend_set),
      .int_ack  (int_ack),
      .int_req  (int_req),
      .int_vect (int_vect)
   );

endmodule

// File: tb/tb_xm23_dev_responder.sv
// Directed bench for xm23_dev_responder; the timer section runs only when
// DEV_TIMER_EN is defined.
module tb_xm23_dev_responder;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] addr = 16'h0000;
   logic [15:0] wdata = 16'h0000;
   logic        rd_en = 1'b0;
   logic        wr_en = 1'b0;
   logic        byte_sel = 1'b0;
   logic [15:0] rdata;
   logic        ack;
   logic        rx_valid = 1'b0;
   logic [7:0]  rx_data = 8'h00;
   logic        rx_ready;
   logic        tx_valid;
   logic [7:0]  tx_data;
   logic        tx_ready = 1'b0;
   logic        int_req;
   logic [3:0]  int_vect;
   logic        int_ack = 1'b0;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   xm23_dev_responder #(
      .BASE_ADDR (16'h0000),
      .VECT_BASE (4'd0),
      .TICK_DIV  (16'd4)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .addr     (addr),
      .wdata    (wdata),
      .rd_en    (rd_en),
      .wr_en    (wr_en),
      .byte_sel (byte_sel),
      .rdata    (rdata),
      .ack      (ack),
      .rx_valid (rx_valid),
      .rx_data  (rx_data),
      .rx_ready (rx_ready),
      .tx_valid (tx_valid),
      .tx_data  (tx_data),
      .tx_ready (tx_ready),
      .int_req  (int_req),
      .int_vect (int_vect),
      .int_ack  (int_ack)
   );

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic bus_rd(input logic [15:0] a, input logic bsel, output logic [15:0] d);
      @(negedge clk);
      addr = a; byte_sel = bsel; rd_en = 1'b1;
      @(negedge clk);
      rd_en = 1'b0;
      d = rdata;
      check("rd_ack", {15'b0, ack}, 16'd1);
      $display("RD  addr=%h byte=%0b data=%h", a, bsel, d);
   endtask

   task automatic bus_wr(input logic [15:0] a, input logic bsel, input logic [15:0] v);
      @(negedge clk);
      addr = a; byte_sel = bsel; wdata = v; wr_en = 1'b1;
      @(negedge clk);
      wr_en = 1'b0;
      check("wr_ack", {15'b0, ack}, 16'd1);
      $display("WR  addr=%h byte=%0b data=%h", a, bsel, v);
   endtask

   task automatic rx_pulse(input logic [7:0] v);
      @(negedge clk);
      rx_valid = 1'b1; rx_data = v;
      @(negedge clk);
      rx_valid = 1'b0;
      $display("RX  data=%h", v);
   endtask

   task automatic tx_drain();
      @(negedge clk);
      tx_ready = 1'b1;
      @(negedge clk);
      tx_ready = 1'b0;
      $display("TX  drained");
   endtask

   task automatic irq_ack();
      @(negedge clk);
      int_ack = 1'b1;
      @(negedge clk);
      int_ack = 1'b0;
      $display("IACK vect_now=%h req_now=%0b", int_vect, int_req);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] d;

      // Reset values
      #7;
      check("rst_rdata", rdata, 16'h0000);
      check("rst_ack", {15'b0, ack}, 16'd0);
      check("rst_int_req", {15'b0, int_req}, 16'd0);
      check("rst_int_vect", {12'b0, int_vect}, 16'd0);
      check("rst_tx_valid", {15'b0, tx_valid}, 16'd0);
      check("rst_rx_ready", {15'b0, rx_ready}, 16'd1);
      @(negedge clk);
      rst_n = 1'b1;

      // Reset in mid transfer drops tx_valid without a clock edge
      bus_wr(16'h0003, 1'b1, 16'h005A);
      check("tx_before_rst", {15'b0, tx_valid}, 16'd1);
      #2 rst_n = 1'b0;
      #1;
      check("tx_async_rst", {15'b0, tx_valid}, 16'd0);
      check("txd_async_rst", {8'h00, tx_data}, 16'h0000);
      @(negedge clk);
      rst_n = 1'b1;
      bus_rd(16'h0002, 1'b0, d);
      check("csr1_reset_word", d, 16'h0016);
      @(negedge clk);
      check("ack_drop", {15'b0, ack}, 16'd0);

      // Receiver with interrupt
      bus_wr(16'h0000, 1'b1, 16'h0011);
      rx_pulse(8'hA5);
      check("rx_int_req", {15'b0, int_req}, 16'd1);
      check("rx_int_vect", {12'b0, int_vect}, 16'd0);
      bus_rd(16'h0001, 1'b1, d);
      check("dr0_a5", d, 16'h00A5);
      bus_rd(16'h0000, 1'b1, d);
      check("csr0_dba_clr", d, 16'h0011);
      irq_ack();
      check("rx_int_cleared", {15'b0, int_req}, 16'd0);
      bus_wr(16'h0000, 1'b1, 16'h0010);

      // Overrun and OF clear
      rx_pulse(8'h11);
      rx_pulse(8'h22);
      bus_rd(16'h0000, 1'b1, d);
      check("csr0_overrun", d, 16'h001C);
      check("no_int_ie0", {15'b0, int_req}, 16'd0);
      bus_wr(16'h0000, 1'b1, 16'h0010);
      bus_rd(16'h0000, 1'b1, d);
      check("csr0_of_clr", d, 16'h0014);
      bus_rd(16'h0000, 1'b0, d);
      check("word0", d, 16'h2214);
      bus_rd(16'h0000, 1'b1, d);
      check("csr0_after_word", d, 16'h0010);

      // Byte arrival in the same cycle as a DR0 read
      rx_pulse(8'h44);
      @(negedge clk);
      addr = 16'h0001; byte_sel = 1'b1; rd_en = 1'b1; rx_valid = 1'b1; rx_data = 8'h55;
      @(negedge clk);
      rd_en = 1'b0; rx_valid = 1'b0;
      check("race_old_dr0", rdata, 16'h0044);
      $display("RD  addr=0001 byte=1 data=%h with RX 55", rdata);
      bus_rd(16'h0000, 1'b1, d);
      check("race_csr0", d, 16'h0014);
      bus_rd(16'h0001, 1'b1, d);
      check("race_new_dr0", d, 16'h0055);

      // Read and write together; out-of-range offsets
      @(negedge clk);
      addr = 16'h0001; byte_sel = 1'b1; wdata = 16'hFFFF; rd_en = 1'b1; wr_en = 1'b1;
      @(negedge clk);
      rd_en = 1'b0; wr_en = 1'b0;
      check("rdwr_rdata", rdata, 16'h0000);
      check("rdwr_ack", {15'b0, ack}, 16'd1);
      $display("RDWR addr=0001 data=%h", rdata);
`ifndef DEV_TIMER_EN
      bus_rd(16'h0004, 1'b0, d);
      check("oor_off4", d, 16'h0000);
`endif
      bus_rd(16'h0006, 1'b0, d);
      check("oor_off6", d, 16'h0000);
      bus_rd(16'hFFFE, 1'b0, d);
      check("oor_below", d, 16'h0000);
      bus_wr(16'h0006, 1'b0, 16'h1234);

      // Transmitter with overrun
      bus_wr(16'h0003, 1'b1, 16'h005A);
      check("tx_valid_1", {15'b0, tx_valid}, 16'd1);
      check("tx_data_5a", {8'h00, tx_data}, 16'h005A);
      bus_rd(16'h0002, 1'b1, d);
      check("csr1_busy", d, 16'h0012);
      bus_wr(16'h0003, 1'b1, 16'h005B);
      check("tx_data_5b", {8'h00, tx_data}, 16'h005B);
      bus_rd(16'h0002, 1'b1, d);
      check("csr1_of", d, 16'h001A);
      tx_drain();
      check("tx_valid_drop", {15'b0, tx_valid}, 16'd0);
      bus_rd(16'h0002, 1'b1, d);
      check("csr1_done", d, 16'h001E);
      bus_wr(16'h0002, 1'b1, 16'h0010);
      bus_rd(16'h0002, 1'b0, d);
      check("word1", d, 16'h5B16);

      // Stores ignored while disabled; word store hits CSR and DR
      bus_wr(16'h0002, 1'b1, 16'h0000);
      bus_wr(16'h0003, 1'b1, 16'h00C3);
      check("tx_disabled", {15'b0, tx_valid}, 16'd0);
      bus_wr(16'h0002, 1'b1, 16'h0010);
      bus_wr(16'h0002, 1'b0, 16'h6610);
      check("tx_word_store", {8'h00, tx_data}, 16'h0066);
      check("tx_word_valid", {15'b0, tx_valid}, 16'd1);
      tx_drain();

      // Two devices pending, priority and ack
      bus_wr(16'h0000, 1'b1, 16'h0011);
      bus_wr(16'h0002, 1'b1, 16'h0011);
      rx_pulse(8'h33);
      bus_wr(16'h0003, 1'b1, 16'h0077);
      tx_drain();
      check("both_req", {15'b0, int_req}, 16'd1);
      check("both_vect0", {12'b0, int_vect}, 16'd0);
      bus_wr(16'h0002, 1'b1, 16'h0010);
      @(negedge clk);
      int_ack = 1'b1; rx_valid = 1'b1; rx_data = 8'h34;
      @(negedge clk);
      int_ack = 1'b0; rx_valid = 1'b0;
      $display("IACK with RX 34");
      check("ack_race_vect", {12'b0, int_vect}, 16'd0);
      irq_ack();
      check("vect1", {12'b0, int_vect}, 16'd1);
      check("vect1_req", {15'b0, int_req}, 16'd1);
      irq_ack();
      check("all_acked", {15'b0, int_req}, 16'd0);
      check("idle_vect", {12'b0, int_vect}, 16'd0);

`ifdef DEV_TIMER_EN
      begin
         int cyc;
         bus_wr(16'h0005, 1'b1, 16'h0003);
         bus_wr(16'h0004, 1'b1, 16'h0011);
         cyc = 0;
         while (!int_req && cyc < 40) begin
            @(negedge clk);
            cyc++;
         end
         check("tmr_cycles", 16'(cyc), 16'd12);
         check("tmr_vect", {12'b0, int_vect}, 16'd2);
         bus_rd(16'h0004, 1'b1, d);
         check("csr2_dba", d, 16'h0015);
         bus_rd(16'h0004, 1'b1, d);
         check("csr2_dba_clr", d, 16'h0011);
         bus_rd(16'h0005, 1'b1, d);
         check("dr2_reload", d, 16'h0003);
         bus_wr(16'h0004, 1'b1, 16'h0000);
         irq_ack();
         check("tmr_acked", {15'b0, int_req}, 16'd0);
      end
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/xm23_dev_responder.md
Name: xm23_dev_responder

Overview:
- Memory-bus responder for the XM23 device space. Answers CPU byte/word loads and stores at BASE_ADDR..BASE_ADDR+5.
- Implements XM23-style CSR/DR pairs for:
  - dev0: input stream receiver.
  - dev1: output stream transmitter.
  - dev2: optional interval timer.
- Raises interrupt requests with a vector number for the CPU's vector-fetch logic, and accepts an acknowledge back.
- Sits beside `memory` on the CPU's MAR/MDR bus.

Parameters:
- BASE_ADDR, 16'h0000, byte address of dev0 CSR. Must be even.
- VECT_BASE, 4'd0, vector number of dev0. Device n uses VECT_BASE+n.
- TICK_DIV, 16'd50000, Clock cycles per timer tick. Used only with DEV_TIMER_EN.

Ports:
- Clock  in  1  system clock, rising-edge.
- Reset_n  in  1  asynchronous active-low reset.
- Addr  in  16  byte address from MAR.
- WData  in  16  store data from MDR.
- RdEn  in  1  load strobe, one cycle.
- WrEn  in  1  store strobe, one cycle.
- ByteSel  in  1  1 = byte access, 0 = word access.
- RData  out  16  load data.
- Ack  out  1  one-cycle pulse; marks completion of any access.
- RxValid  in  1  incoming byte valid.
- RxData  in  8  incoming byte.
- RxReady  out  1  receiver accepts the byte.
- TxValid  out  1  outgoing byte valid.
- TxData  out  8  outgoing byte.
- TxReady  in  1  sink accepts the byte.
- IntReq  out  1  interrupt pending.
- IntVect  out  4  vector of the highest-priority pending device.
- IntAck  in  1  one-cycle acknowledge of IntVect.

Behaviour:
- Reset (asynchronous, Reset_n=0):
  - RData=0, Ack=0, TxValid=0, TxData=0, IntReq=0, IntVect=VECT_BASE.
  - All pending bits clear.
  - CSR values after reset:
    - dev0: IE=0, ENA=1, DBA=0, OF=0.
    - dev1: IE=0, ENA=1, DBA=1 (ready), OF=0.
  - A reset mid-transfer drops TxValid immediately; the byte is lost.
- Address map (offset from BASE_ADDR): device n CSR at 2n, DR at 2n+1.
  - Word access at offset 2n: RData = {DR,CSR}.
  - Word store at offset 2n writes CSR from WData[7:0] and DR from WData[15:8].
  - Odd-address word access is treated as a byte access.
  - Out-of-range offset: RData=0, writes ignored, Ack still pulses.
- CSR bits:
  - 0 IE, read/write.
  - 1 IO, read-only: 0 for dev0/dev2, 1 for dev1.
  - 2 DBA, read-only.
  - 3 OF, writing 0 clears it; writing 1 has no effect.
  - 4 ENA, read/write.
  - 7:5 read as 0.
- Latency: RData and Ack are registered one cycle after RdEn/WrEn. RdEn and WrEn together: the write wins and RData returns 0.
- dev0 receiver:
  - RxReady = ENA0.
  - Each RxValid&RxReady cycle:
    - DR0 <= RxData.
    - OF0 set if DBA0 was already 1.
    - DBA0 <= 1.
    - pending0 set if IE0=1.
  - A read of DR0 clears DBA0.
  - Same-cycle byte arrival and DR0 read: RData returns the old DR0, DBA0 stays 1, OF0 unchanged.
- dev1 transmitter:
  - Store to DR1 with ENA1=1:
    - TxData <= byte, TxValid <= 1, DBA1 <= 0.
    - If DBA1 was 0: OF1 <= 1 and TxData is replaced.
  - TxValid&TxReady: TxValid <= 0, DBA1 <= 1, pending1 set if IE1=1.
  - Store while ENA1=0: ignored.
- Interrupts:
  - IntReq = |pending.
  - Fixed priority: dev0 > dev1 > dev2.
  - IntAck clears the pending bit selected by IntVect that cycle.
  - If a new event for the same device arrives in the ack cycle, that bit stays set.
  - Clearing IE does not clear an existing pending bit.
- Width rules: all byte paths are 8 bit; the upper RData byte is zero-filled on byte reads.

Optional Feature:
- Macro: DEV_TIMER_EN.
- With DEV_TIMER_EN, dev2 is an interval timer:
  - DR2 is the reload value; storing DR2 loads the counter.
  - While ENA2=1 and the counter is nonzero, it decrements once every TICK_DIV cycles.
  - On reaching 0: DBA2 <= 1 (OF2 set if DBA2 was already 1), counter reloads from DR2, pending2 set if IE2=1.
  - A read of CSR2 clears DBA2.
  - Reset value of CSR2: ENA2=0.
- Without DEV_TIMER_EN, offsets 4 and 5 are out of range and pending2 is held at 0.

Decomposition:
- Package xm23_dev_pkg holds:
  - CSR bit indices: CSR_IE, CSR_IO, CSR_DBA, CSR_OF, CSR_ENA.
  - Device indices DEV_RX, DEV_TX, DEV_TMR.
  - Offset constants.
  - The typedef for a device CSR struct.
- One sub-module, xm23_irq_arbiter: pending register, set/ack logic, priority encoding to IntVect.

Test Plan:
- Reset with TxValid=1 mid-transfer -> TxValid=0 asynchronously. After release, word read at offset 2 returns 16'h0016 (ENA, DBA, IO).
- IE0 set, RxData=8'hA5 pulsed -> IntReq=1, IntVect=VECT_BASE. Byte read at offset 1 returns 16'h00A5 with Ack one cycle later, and DBA0 clears.
- Two RxData bytes 8'h11 then 8'h22 with no read -> CSR0 reads 16'h001C (ENA, OF, DBA) and DR0=8'h22. Write 8'h10 to CSR0 -> OF0 clears.
- Store 8'h5A to offset 3 with TxReady=0 -> TxValid=1, TxData=8'h5A, DBA1=0. Second store 8'h5B -> OF1=1, TxData=8'h5B. TxReady=1 -> TxValid drops, DBA1=1.
- dev0 and dev1 pending together -> IntVect=VECT_BASE. IntAck -> IntVect=VECT_BASE+1. Another IntAck -> IntReq=0.
- DEV_TIMER_EN with TICK_DIV=4, DR2=3, ENA2=1, IE2=1 -> pending2 after 12 cycles, counter reloads to 3. Without the macro, a read at offset 4 returns 0.
